// File: rtl/ib_seq.sv
// Writer-side sequencer for the input buffer: stages `vector` words from a valid/ready
// source, bursts them in with ctl=1, then issues REPEAT address-reset + read-out passes.
module ib_seq #(
  parameter int unsigned width  = 16,
  parameter int unsigned vector = 4,
  parameter int unsigned REPEAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             src_valid,
  input  logic [width-1:0] src_data,
  output logic             src_ready,
  output logic [1:0]       ib_ctl,
  output logic [width-1:0] ib_in,
  output logic             ib_out_valid,
  output logic [7:0]       ib_out_idx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = 8;
  localparam int unsigned IW = (vector > 1) ? $clog2(vector) : 1;
  localparam logic [CW-1:0] LAST  = CW'(vector - 1);
  localparam logic [CW-1:0] PLAST = CW'(REPEAT - 1);

  localparam logic [1:0] CTL_IDLE  = 2'd0;
  localparam logic [1:0] CTL_STORE = 2'd1;
  localparam logic [1:0] CTL_OUT   = 2'd2;
  localparam logic [1:0] CTL_CLR   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_BURST, S_GAP, S_READ, S_FIN, S_ABORT
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   wcnt, wcnt_n, idx, idx_n, pass, pass_n;
  logic [width-1:0] stage [vector];
  logic            hs_c;

  logic [1:0]       ctl_n;
  logic [width-1:0] in_n;
  logic             ready_n, ov_n, busy_n, done_n;
  logic [7:0]       oidx_n;

  assign hs_c = (state == S_LOAD) && src_valid && src_ready && !abort;

  // Next state, counters, and the registered-output values for the next cycle.
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    idx_n   = idx;
    pass_n  = pass;
    ctl_n   = CTL_IDLE;
    in_n    = '0;
    ready_n = 1'b0;
    ov_n    = 1'b0;
    oidx_n  = '0;
    busy_n  = 1'b0;
    done_n  = 1'b0;

    case (state)
      S_IDLE:  if (start && !abort) state_n = S_CLR;
      S_CLR:   state_n = S_LOAD;
      S_LOAD: begin
        if (hs_c) begin
          wcnt_n = wcnt + CW'(1);
          if (wcnt == LAST) begin
            state_n = S_BURST;
            idx_n   = '0;
          end
        end
      end
      S_BURST: begin
        if (idx == LAST) begin
          state_n = S_GAP;
          idx_n   = '0;
        end else begin
          idx_n = idx + CW'(1);
        end
      end
      S_GAP: begin
        state_n = S_READ;
        idx_n   = '0;
      end
      S_READ: begin
        if (idx == LAST) begin
          idx_n = '0;
          if (pass != PLAST) begin
            pass_n  = pass + CW'(1);
            state_n = S_GAP;
          end else begin
            state_n = S_FIN;
          end
        end else begin
          idx_n = idx + CW'(1);
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
        pass_n  = '0;
        wcnt_n  = '0;
      end
      S_ABORT: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Abort overrides everything; a second abort while already aborting is absorbed.
    if (abort && state != S_IDLE && state != S_ABORT) begin
      state_n = S_ABORT;
      wcnt_n  = '0;
      idx_n   = '0;
      pass_n  = '0;
    end

    case (state_n)
      S_CLR, S_ABORT: ctl_n = CTL_CLR;
      S_BURST:        ctl_n = CTL_STORE;
      S_READ:         ctl_n = CTL_OUT;
      default:        ctl_n = CTL_IDLE;
    endcase

    if (state_n == S_BURST) in_n = stage[IW'(idx_n)];
    ready_n = (state_n == S_LOAD);
    // Buffer output is registered, so a READ cycle's word shows up one cycle later.
    ov_n    = (state == S_READ) && (state_n != S_ABORT);
    oidx_n  = ov_n ? idx : '0;
    busy_n  = (state_n != S_IDLE);
    done_n  = (state_n == S_FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      wcnt         <= '0;
      idx          <= '0;
      pass         <= '0;
      src_ready    <= 1'b0;
      ib_ctl       <= CTL_IDLE;
      ib_in        <= '0;
      ib_out_valid <= 1'b0;
      ib_out_idx   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      for (int i = 0; i < int'(vector); i++) stage[i] <= '0;
    end else begin
      state        <= state_n;
      wcnt         <= wcnt_n;
      idx          <= idx_n;
      pass         <= pass_n;
      src_ready    <= ready_n;
      ib_ctl       <= ctl_n;
      ib_in        <= in_n;
      ib_out_valid <= ov_n;
      ib_out_idx   <= oidx_n;
      busy         <= busy_n;
      done         <= done_n;
      if (hs_c) stage[IW'(wcnt)] <= src_data;
    end
  end

endmodule
